// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared encodings for the load/store unit: RV32I width/sign codes, FSM state
// encodings and small decode helpers used when a request is accepted.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // RV32I funct3 width/sign codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    // Unused funct3 codes (011, 110, 111) behave as a word access.
    function automatic logic [2:0] norm_funct3(input logic [2:0] f3);
        logic [2:0] r;
        case (f3)
            F3_B, F3_H, F3_BU, F3_HU: r = f3;
            default:                  r = F3_W;
        endcase
        return r;
    endfunction

    // Byte accesses are always aligned; halfwords need addr[0]=0 and words
    // need addr[1:0]=00. Expects a normalised funct3.
    function automatic logic is_misaligned(input logic [2:0] f3n, input logic [1:0] addr_lo);
        logic r;
        case (f3n)
            F3_H, F3_HU: r = addr_lo[0];
            F3_W:        r = |addr_lo;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic: byte-enable generation, store data replication and
// load lane selection with sign/zero extension.
// Ports:
//   funct3    in  3   normalised width/sign code
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  store data (rs2)
//   rdata     in  32  word read from memory
//   be        out 4   byte-lane enables
//   wdata_rep out 32  store data replicated across lanes
//   rdata_ext out 32  selected load lane, extended to 32 bits
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        // Bring the addressed lane down to bit 0 so one slice serves all offsets.
        shifted   = rdata >> {addr_lo, 3'b000};
        byte_s    = shifted[7:0];
        half_s    = shifted[15:0];
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = 32'(byte_s);
            end
            F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h000000, shifted[7:0]};
            end
            F3_H: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = 32'(half_s);
            end
            F3_HU: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0000, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit between the core and a ready-handshake memory port. Accepts
// one operation at a time, checks alignment, drives a word-addressed memory
// request with byte enables, extends load data and reports completion with a
// one-cycle rsp_valid pulse. A memory that never answers is aborted after
// TIMEOUT request cycles.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/we/funct3/addr/wdata core request (held by core until rsp_valid)
//   busy                           operation in flight
//   rsp_valid/rdata/misalign/timeout  completion pulse and status
//   mem_req/we/addr/be/wdata       memory request, stable until mem_ready
//   mem_ready, mem_rdata           memory completion and read word
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] cnt;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        flag_mis;
    logic        flag_tout;
    logic [31:0] data_r;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic [2:0]  req_f3n;

    assign req_f3n = norm_funct3(req_funct3);

    // Lane logic works only on latched fields, so nothing on req_* reaches mem_*.
    lsu_align u_align (
        .funct3    (lat_f3),
        .addr_lo   (lat_addr[1:0]),
        .wdata     (lat_wdata),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lat_we       <= 1'b0;
            lat_f3       <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            flag_mis     <= 1'b0;
            flag_tout    <= 1'b0;
            data_r       <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            // Response fields are zero whenever rsp_valid is low.
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
            rsp_timeout  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_f3n;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        flag_mis  <= is_misaligned(req_f3n, req_addr[1:0]);
                        flag_tout <= 1'b0;
                        data_r    <= '0;
                        cnt       <= '0;
                        state     <= is_misaligned(req_f3n, req_addr[1:0]) ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A ready on the final counted cycle still wins over the timeout.
                    if (mem_ready) begin
                        data_r <= lat_we ? 32'h0 : al_rdata;
                        state  <= ST_RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        flag_tout <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= data_r;
                    rsp_misalign <= flag_mis;
                    rsp_timeout  <= flag_tout;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign mem_req   = (state == ST_ACCESS);
    assign mem_we    = mem_req & lat_we;
    assign mem_addr  = {lat_addr[31:2], 2'b00};
    assign mem_be    = mem_req ? al_be : 4'b0000;
    assign mem_wdata = mem_req ? al_wdata : 32'h0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .rsp_timeout(rsp_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        bit          unstable;
        int          rsp_step;
        logic [31:0] rdata;
        logic        mis;
        logic        tout;
        bit          busy_err;
    } obs_t;

    // ---------------- reference model (arithmetic on the rules) ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_signed(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd1);
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = m_size(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = m_size(f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        int sz = m_size(f3);
        logic [31:0] v;
        logic [31:0] lim;
        if (sz == 4) return word;
        lim = 32'd1 << (8 * sz);
        v = (word >> (8 * (addr % 4))) % lim;
        if (m_signed(f3) && v >= lim / 2) v = v - lim;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, answers mem_req after `delay` wait cycles (delay<0:
    // never), and returns when rsp_valid is seen (or the cycle budget runs out).
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int delay, output obs_t o);
        o = '{default: 0};
        o.rsp_step = -1;
        o.busy_err = busy;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_rdata  = rdata;
        mem_ready  = 1'b0;
        for (int s = 1; s <= T + 12; s++) begin
            step();
            if (s == 1) begin
                // Request inputs are ignored while busy; scramble them.
                req_we     = ~we;
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            if (rsp_valid) begin
                o.rsp_step = s;
                o.rdata    = rsp_rdata;
                o.mis      = rsp_misalign;
                o.tout     = rsp_timeout;
                if (busy) o.busy_err = 1;
                req_valid = 1'b0;
                mem_ready = 1'b0;
                break;
            end
            if (!busy) o.busy_err = 1;
            if (mem_req) begin
                if (o.req_cycles == 0) begin
                    o.addr  = mem_addr;
                    o.be    = mem_be;
                    o.wdata = mem_wdata;
                    o.we    = mem_we;
                end else if (mem_addr !== o.addr || mem_be !== o.be ||
                             mem_wdata !== o.wdata || mem_we !== o.we) begin
                    o.unstable = 1;
                end
                o.req_cycles++;
                mem_ready = (delay >= 0 && o.req_cycles - 1 == delay);
            end else begin
                mem_ready = 1'($urandom);
            end
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0000_0100; req_wdata = 32'hFFFF_FFFF;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if ({rsp_misalign, rsp_timeout} !== 2'b00) begin errors++; $display("FAIL reset_rsp_flags: got %b want 00", {rsp_misalign, rsp_timeout}); end
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_req_we: got %b want 00", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be: got %h want 0", mem_be); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_directed();
        obs_t o;
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, o);
        checks++; if (o.addr !== 32'h100 || o.be !== 4'hF) begin errors++; $display("FAIL lw_addr_be: got %h/%h want 00000100/f", o.addr, o.be); end
        checks++; if (o.req_cycles !== 3) begin errors++; $display("FAIL lw_req_cycles: got %0d want 3", o.req_cycles); end
        checks++; if (o.rsp_step !== 5) begin errors++; $display("FAIL lw_latency: got %0d want 5", o.rsp_step); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", o.rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse_width: got %b want 0", rsp_valid); end

        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, o);
        checks++; if (o.be !== 4'b1000 || o.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_103: got be %b rdata %h want 1000 ffffff80", o.be, o.rdata); end
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, o);
        checks++; if (o.be !== 4'b1000 || o.rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_103: got be %b rdata %h want 1000 00000080", o.be, o.rdata); end
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 0, o);
        checks++; if (o.be !== 4'b1100 || o.rdata !== 32'h000080FF) begin errors++; $display("FAIL lhu_102: got be %b rdata %h want 1100 000080ff", o.be, o.rdata); end

        run_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFF_FFFF, 1, o);
        checks++; if (o.we !== 1'b1 || o.be !== 4'b1100) begin errors++; $display("FAIL sh_we_be: got %b/%b want 1/1100", o.we, o.be); end
        checks++; if (o.wdata !== 32'hABCDABCD || o.addr !== 32'h200) begin errors++; $display("FAIL sh_wdata_addr: got %h/%h want abcdabcd/00000200", o.wdata, o.addr); end
        checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h want 0", o.rdata); end

        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h5555_5555, 0, o);
        checks++; if (o.req_cycles !== 0 || o.rsp_step !== 2 || o.mis !== 1'b1) begin errors++; $display("FAIL lw_misalign: got req %0d step %0d mis %b want 0 2 1", o.req_cycles, o.rsp_step, o.mis); end
        run_op(1'b1, 3'b001, 32'h203, 32'h1234, 32'h0, 0, o);
        checks++; if (o.req_cycles !== 0 || o.rsp_step !== 2 || o.mis !== 1'b1 || o.rdata !== 32'h0) begin errors++; $display("FAIL sh_misalign: got req %0d step %0d mis %b rdata %h want 0 2 1 0", o.req_cycles, o.rsp_step, o.mis, o.rdata); end
        checks++; if (o.busy_err) begin errors++; $display("FAIL directed_busy: got busy error 1 want 0"); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, -1, o);
        checks++; if (o.req_cycles !== T) begin errors++; $display("FAIL timeout_req_cycles: got %0d want %0d", o.req_cycles, T); end
        checks++; if (o.tout !== 1'b1 || o.rdata !== 32'h0 || o.mis !== 1'b0) begin errors++; $display("FAIL timeout_flags: got tout %b rdata %h mis %b want 1 0 0", o.tout, o.rdata, o.mis); end
        checks++; if (o.rsp_step !== T + 2) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", o.rsp_step, T + 2); end
        run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'h3333_4444, T - 1, o);
        checks++; if (o.tout !== 1'b0 || o.rdata !== 32'h3333_4444 || o.req_cycles !== T) begin errors++; $display("FAIL ready_last_cycle: got tout %b rdata %h req %0d want 0 33334444 %0d", o.tout, o.rdata, o.req_cycles, T); end
    endtask

    task automatic test_reset_in_access();
        obs_t o;
        bit   seen;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        step();
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_pre_req: got %b want 1", mem_req); end
        rst = 1'b1;
        step();
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_drop: got req %b busy %b want 0 0", mem_req, busy); end
        rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            step();
            if (rsp_valid || busy) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: got activity 1 want 0"); end
        mem_ready = 1'b0;
        run_op(1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 1, o);
        checks++; if (o.rdata !== 32'hCAFE_F00D || o.rsp_step !== 4 || o.addr !== 32'h44) begin errors++; $display("FAIL abort_next_op: got rdata %h step %0d addr %h want cafef00d 4 00000044", o.rdata, o.rsp_step, o.addr); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        we;
        logic [2:0]  f3, f3n;
        logic [31:0] addr, wd, rd, exp_rd;
        int          delay, exp_step, exp_cyc;
        bit          mis, tout;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom);
            f3    = 3'($urandom);
            addr  = $urandom;
            wd    = $urandom;
            rd    = $urandom;
            delay = int'($urandom_range(0, 6)) - 1;
            if (delay == 5) delay = -1;
            f3n   = (f3 == 3'd3 || f3 >= 3'd6) ? 3'd2 : f3;
            mis   = m_mis(f3n, addr);
            tout  = !mis && (delay < 0 || delay > T - 1);
            exp_cyc  = mis ? 0 : (tout ? T : delay + 1);
            exp_step = mis ? 2 : (tout ? T + 2 : delay + 3);
            exp_rd   = (mis || tout || we) ? 32'h0 : m_load(f3n, addr, rd);
            run_op(we, f3, addr, wd, rd, delay, o);
            checks++; if (o.rsp_step !== exp_step || o.req_cycles !== exp_cyc) begin errors++; $display("FAIL rnd%0d_timing: got step %0d req %0d want %0d %0d", i, o.rsp_step, o.req_cycles, exp_step, exp_cyc); end
            checks++; if (o.mis !== mis || o.tout !== tout) begin errors++; $display("FAIL rnd%0d_flags: got mis %b tout %b want %b %b", i, o.mis, o.tout, mis, tout); end
            checks++; if (o.rdata !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", i, o.rdata, exp_rd); end
            checks++; if (o.busy_err || o.unstable) begin errors++; $display("FAIL rnd%0d_busy_stable: got busy_err %b unstable %b want 0 0", i, o.busy_err, o.unstable); end
            if (!mis) begin
                checks++;
                if (o.addr !== (addr & 32'hFFFF_FFFC) || o.be !== m_be(f3n, addr) ||
                    o.wdata !== m_wdata(f3n, wd) || o.we !== we) begin
                    errors++;
                    $display("FAIL rnd%0d_mem: got %h %h %h %b want %h %h %h %b", i, o.addr, o.be, o.wdata, o.we,
                             addr & 32'hFFFF_FFFC, m_be(f3n, addr), m_wdata(f3n, wd), we);
                end
            end
        end
    endtask

    task automatic test_ready_idle();
        bit seen = 0;
        mem_ready = 1'b1; req_valid = 1'b0;
        repeat (4) begin
            step();
            if (busy || rsp_valid || mem_req) seen = 1;
        end
        mem_ready = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ready_while_idle: got activity 1 want 0"); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_directed();
        test_timeout();
        test_reset_in_access();
        test_ready_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
